// File: rtl/player_motion_fsm.sv
// Player-sprite motion controller: STAND/RUN/JUMP/CROUCH state machine advancing one game step
// per unpaused tick, with divided run animation, gravity jump and clamped landing.
module player_motion_fsm #(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned VEL_W      = 8,
    parameter int unsigned GROUND_X   = 95,
    parameter int unsigned CROUCH_X   = 53,
    parameter int unsigned Y_RUN      = 129,
    parameter int unsigned Y_CROUCH   = 123,
    parameter int unsigned JUMP_VEL   = 14,
    parameter int unsigned GRAVITY    = 2,
    parameter int unsigned RUN_FRAMES = 3,
    parameter int unsigned ANIM_DIV   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            pause,
    input  logic [3:0]      keys,
    output logic [X_W-1:0]  x_pos,
    output logic [Y_W-1:0]  y_pos,
    output logic [ID_W-1:0] sprite_id,
    output logic            airborne,
    output logic            landed,
    output logic [1:0]      state_o
);

    localparam logic [1:0] ST_STAND  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_JUMP   = 2'd2;
    localparam logic [1:0] ST_CROUCH = 2'd3;

    localparam int unsigned CNT_W = $clog2(ANIM_DIV + 1);
    localparam int unsigned SX_W  = X_W + 2;

    localparam logic [ID_W-1:0] LAST_RUN_ID = ID_W'(RUN_FRAMES - 1);
    localparam logic [ID_W-1:0] JUMP_ID     = ID_W'(RUN_FRAMES);
    localparam logic [ID_W-1:0] CROUCH_ID   = ID_W'(RUN_FRAMES + 1);
    localparam logic [ID_W-1:0] STAND_ID    = ID_W'(RUN_FRAMES + 2);

    localparam logic [X_W-1:0] GROUND_XV = X_W'(GROUND_X);
    localparam logic [X_W-1:0] CROUCH_XV = X_W'(CROUCH_X);
    localparam logic [Y_W-1:0] Y_RUN_V    = Y_W'(Y_RUN);
    localparam logic [Y_W-1:0] Y_CROUCH_V = Y_W'(Y_CROUCH);

    localparam logic signed [SX_W-1:0]  GROUND_S = SX_W'(GROUND_X);
    localparam logic signed [SX_W-1:0]  X_MAX_S  = SX_W'((1 << X_W) - 1);
    localparam logic signed [VEL_W-1:0] JUMP_V   = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] GRAV_V   = VEL_W'(GRAVITY);
    localparam logic [CNT_W-1:0]        DIV_V    = CNT_W'(ANIM_DIV);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);

    logic [1:0]              state, state_nx;
    logic signed [VEL_W-1:0] vel, vel_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx, cnt_inc;
    logic [X_W-1:0]          x_nx;
    logic [Y_W-1:0]          y_nx;
    logic [ID_W-1:0]         id_nx;
    logic                    landed_nx;

    logic                    step;
    logic                    jump_key;
    logic                    crouch_key;
    logic signed [SX_W-1:0]  jump_sum;
    logic                    unused_keys_c;

    // Keys are active-low; the reserved pair is deliberately ignored.
    assign step          = tick & ~pause;
    assign jump_key      = ~keys[0];
    assign crouch_key    = ~keys[1];
    assign unused_keys_c = ^keys[3:2];
    assign cnt_inc       = cnt + CNT_ONE;
    assign jump_sum      = $signed({2'b00, x_pos}) + $signed(SX_W'(vel));
    assign state_o       = state;

    // Next-state and next-output logic; everything holds unless a step occurs.
    always_comb begin
        state_nx  = state;
        x_nx      = x_pos;
        y_nx      = y_pos;
        id_nx     = sprite_id;
        vel_nx    = vel;
        cnt_nx    = cnt;
        landed_nx = 1'b0;
        if (step) begin
            case (state)
                ST_STAND: begin
                    if (jump_key || crouch_key) begin
                        state_nx = ST_RUN;
                        x_nx     = GROUND_XV;
                        y_nx     = Y_RUN_V;
                        id_nx    = '0;
                        cnt_nx   = '0;
                    end
                end
                ST_RUN: begin
                    x_nx = GROUND_XV;
                    y_nx = Y_RUN_V;
                    if (jump_key) begin
                        state_nx = ST_JUMP;
                        vel_nx   = JUMP_V;
                        id_nx    = JUMP_ID;
                    end else if (crouch_key) begin
                        state_nx = ST_CROUCH;
                        x_nx     = CROUCH_XV;
                        y_nx     = Y_CROUCH_V;
                        id_nx    = CROUCH_ID;
                    end else if (cnt_inc == DIV_V) begin
                        cnt_nx = '0;
                        id_nx  = (sprite_id == LAST_RUN_ID) ? '0 : sprite_id + ID_W'(1);
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                ST_JUMP: begin
                    vel_nx = vel - GRAV_V;
                    // Falling past the floor snaps to the floor and ends the jump.
                    if (vel[VEL_W-1] && (jump_sum <= GROUND_S)) begin
                        state_nx  = ST_RUN;
                        x_nx      = GROUND_XV;
                        y_nx      = Y_RUN_V;
                        id_nx     = '0;
                        cnt_nx    = '0;
                        vel_nx    = '0;
                        landed_nx = 1'b1;
                    end else if (jump_sum > X_MAX_S) begin
                        x_nx = '1;
                    end else begin
                        x_nx = X_W'(jump_sum);
                    end
                end
                ST_CROUCH: begin
                    if (!crouch_key) begin
                        state_nx = ST_RUN;
                        x_nx     = GROUND_XV;
                        y_nx     = Y_RUN_V;
                        id_nx    = '0;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = ST_STAND;
                    x_nx     = GROUND_XV;
                    y_nx     = Y_RUN_V;
                    id_nx    = STAND_ID;
                    vel_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_STAND;
            x_pos     <= GROUND_XV;
            y_pos     <= Y_RUN_V;
            sprite_id <= STAND_ID;
            vel       <= '0;
            cnt       <= '0;
            airborne  <= 1'b0;
            landed    <= 1'b0;
        end else begin
            state     <= state_nx;
            x_pos     <= x_nx;
            y_pos     <= y_nx;
            sprite_id <= id_nx;
            vel       <= vel_nx;
            cnt       <= cnt_nx;
            airborne  <= (state_nx == ST_JUMP);
            landed    <= landed_nx;
        end
    end

endmodule

// File: tb/tb_player_motion_fsm.sv
// Bench for player_motion_fsm: two instances (default, and JUMP_VEL=13/ANIM_DIV=2) against a
// step-level behavioural model of the sprite's mode, height and animation frame.
module tb_player_motion_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       pause;
    logic [3:0] keys;

    logic [7:0] xs  [2];
    logic [8:0] ys  [2];
    logic [3:0] ids [2];
    logic       air [2];
    logic       lnd [2];
    logic [1:0] st  [2];

    int total = 0;
    int bad   = 0;

    // Model: mode 0 stand, 1 run, 2 jump, 3 crouch; height and velocity while airborne;
    // number of animated steps since entering RUN.
    int m_mode [2];
    int m_x    [2];
    int m_vel  [2];
    int m_rs   [2];
    bit m_land [2];
    int p_jv   [2] = '{14, 13};
    int p_div  [2] = '{1, 2};

    always #5 clk = ~clk;

    player_motion_fsm dut0 (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .keys(keys),
        .x_pos(xs[0]), .y_pos(ys[0]), .sprite_id(ids[0]), .airborne(air[0]),
        .landed(lnd[0]), .state_o(st[0])
    );

    player_motion_fsm #(.JUMP_VEL(13), .ANIM_DIV(2)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause), .keys(keys),
        .x_pos(xs[1]), .y_pos(ys[1]), .sprite_id(ids[1]), .airborne(air[1]),
        .landed(lnd[1]), .state_o(st[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_x[i] = 95; m_vel[i] = 0; m_rs[i] = 0; m_land[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic t, input logic p, input logic [3:0] k);
        bit jp, cp;
        int nxt;
        m_land[i] = 0;
        if (!(t && !p)) return;
        jp = !k[0];
        cp = !k[1];
        case (m_mode[i])
            0: if (jp || cp) begin m_mode[i] = 1; m_rs[i] = 0; end
            1: begin
                if (jp) begin m_mode[i] = 2; m_x[i] = 95; m_vel[i] = p_jv[i]; end
                else if (cp) m_mode[i] = 3;
                else m_rs[i]++;
            end
            2: begin
                nxt = m_x[i] + m_vel[i];
                if (m_vel[i] < 0 && nxt <= 95) begin
                    m_mode[i] = 1; m_x[i] = 95; m_rs[i] = 0; m_land[i] = 1;
                end else begin
                    m_x[i] = (nxt > 255) ? 255 : nxt;
                end
                m_vel[i] -= 2;
            end
            default: if (!cp) begin m_mode[i] = 1; m_rs[i] = 0; end
        endcase
    endtask

    function automatic logic [24:0] exp_vec(input int i);
        int x, y, id;
        x = 95; y = 129; id = 5;
        case (m_mode[i])
            1: id = (m_rs[i] / p_div[i]) % 3;
            2: begin x = m_x[i]; id = 3; end
            3: begin x = 53; y = 123; id = 4; end
            default: ;
        endcase
        return {2'(m_mode[i]), 8'(x), 9'(y), 4'(id), 1'(m_mode[i] == 2), 1'(m_land[i])};
    endfunction

    function automatic logic [24:0] obs_vec(input int i);
        return {st[i], xs[i], ys[i], ids[i], air[i], lnd[i]};
    endfunction

    // One clock: inputs change on the falling edge, outputs are sampled 1 time unit after rising.
    task automatic do_clk(input logic t, input logic p, input logic [3:0] k);
        @(negedge clk);
        tick = t; pause = p; keys = k;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, t, p, k);
        #1;
    endtask

    task automatic test_reset();
        tick = 0; pause = 0; keys = 4'hF; reset = 1;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_vec(i) !== exp_vec(i)) begin
                bad++; $display("FAIL reset dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        @(negedge clk); reset = 0;
        for (int s = 0; s < 5; s++) begin
            do_clk(1, 0, 4'hF);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    bad++; $display("FAIL stand_hold dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        do_clk(1, 0, 4'hE);
        total++;
        if (st[0] !== 2'd1 || ids[0] !== 4'd0) begin
            bad++; $display("FAIL stand_to_run got st=%0d id=%0d exp st=1 id=0", st[0], ids[0]);
        end
    endtask

    task automatic test_anim();
        int seq0 [7] = '{1, 2, 0, 1, 2, 0, 1};
        int seq1 [7] = '{0, 1, 1, 2, 2, 0, 0};
        for (int s = 0; s < 7; s++) begin
            do_clk(1, 0, 4'hF);
            total++;
            if (ids[0] !== 4'(seq0[s]) || ids[1] !== 4'(seq1[s])) begin
                bad++;
                $display("FAIL anim step%0d got=%0d/%0d exp=%0d/%0d", s, ids[0], ids[1], seq0[s], seq1[s]);
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    bad++; $display("FAIL anim_model dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_jump();
        int tab [15] = '{109, 121, 131, 139, 145, 149, 151, 151, 149, 145, 139, 131, 121, 109, 95};
        do_clk(1, 0, 4'hE);
        total++;
        if (st[0] !== 2'd2 || xs[0] !== 8'd95 || air[0] !== 1'b1) begin
            bad++; $display("FAIL jump_entry got st=%0d x=%0d air=%b exp st=2 x=95 air=1", st[0], xs[0], air[0]);
        end
        for (int s = 0; s < 15; s++) begin
            do_clk(1, 0, 4'hF);
            total++;
            if (xs[0] !== 8'(tab[s])) begin
                bad++; $display("FAIL jump_x step%0d got=%0d exp=%0d", s + 1, xs[0], tab[s]);
            end
            total++;
            if (lnd[0] !== (s == 14) || air[0] !== (s != 14)) begin
                bad++; $display("FAIL jump_flags step%0d got lnd=%b air=%b", s + 1, lnd[0], air[0]);
            end
            total++;
            if (xs[1] < 8'd95) begin
                bad++; $display("FAIL below_floor got=%0d exp>=95", xs[1]);
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    bad++; $display("FAIL jump_model dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        do_clk(0, 0, 4'hF);
        total++;
        if (lnd[0] !== 1'b0 || st[0] !== 2'd1) begin
            bad++; $display("FAIL landed_pulse got lnd=%b st=%0d exp lnd=0 st=1", lnd[0], st[0]);
        end
    endtask

    task automatic test_priority_crouch();
        int guard;
        do_clk(1, 0, 4'hC);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (st[i] !== 2'd2 || obs_vec(i) !== exp_vec(i)) begin
                bad++; $display("FAIL priority dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        guard = 0;
        while ((m_mode[0] != 1 || m_mode[1] != 1) && guard < 40) begin
            do_clk(1, 0, 4'hF);
            guard++;
        end
        total++;
        if (st[0] !== 2'd1 || st[1] !== 2'd1) begin
            bad++; $display("FAIL land_wait got st=%0d/%0d exp=1/1", st[0], st[1]);
        end
        for (int s = 0; s < 4; s++) begin
            do_clk(1, 0, (s == 0) ? 4'hD : 4'hC);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (xs[i] !== 8'd53 || ys[i] !== 9'd123 || ids[i] !== 4'd4 || st[i] !== 2'd3) begin
                    bad++;
                    $display("FAIL crouch dut%0d got x=%0d y=%0d id=%0d st=%0d exp 53/123/4/3",
                             i, xs[i], ys[i], ids[i], st[i]);
                end
            end
        end
        do_clk(1, 0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (xs[i] !== 8'd95 || ys[i] !== 9'd129 || ids[i] !== 4'd0 || st[i] !== 2'd1) begin
                bad++;
                $display("FAIL crouch_release dut%0d got x=%0d y=%0d id=%0d st=%0d exp 95/129/0/1",
                         i, xs[i], ys[i], ids[i], st[i]);
            end
        end
    endtask

    task automatic test_pause_reset();
        logic [7:0] held;
        do_clk(1, 0, 4'hE);
        for (int s = 0; s < 4; s++) do_clk(1, 0, 4'hF);
        held = xs[0];
        for (int s = 0; s < 10; s++) begin
            do_clk(1, 1, 4'($urandom));
            total++;
            if (xs[0] !== held || lnd[0] !== 1'b0 || st[0] !== 2'd2) begin
                bad++; $display("FAIL pause_hold got x=%0d lnd=%b st=%0d exp x=%0d", xs[0], lnd[0], st[0], held);
            end
        end
        do_clk(1, 0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_vec(i) !== exp_vec(i)) begin
                bad++; $display("FAIL pause_resume dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        @(negedge clk);
        tick = 1; keys = 4'hF; pause = 0;
        #2 reset = 1;
        model_reset();
        #1;
        total++;
        if (xs[0] !== 8'd95 || ids[0] !== 4'd5 || lnd[0] !== 1'b0 || st[0] !== 2'd0 || air[0] !== 1'b0) begin
            bad++; $display("FAIL reset_midjump got x=%0d id=%0d lnd=%b st=%0d", xs[0], ids[0], lnd[0], st[0]);
        end
        @(negedge clk); reset = 0;
        do_clk(0, 0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_vec(i) !== exp_vec(i)) begin
                bad++; $display("FAIL post_reset dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_random();
        logic       t, p;
        logic [3:0] k;
        for (int s = 0; s < 400; s++) begin
            t = ($urandom % 4) != 0;
            p = ($urandom % 8) == 0;
            k = {2'($urandom), !(($urandom % 10) < 2), !(($urandom % 10) < 4)};
            do_clk(t, p, k);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    bad++; $display("FAIL random step%0d dut%0d got=%h exp=%h", s, i, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        reset = 1; tick = 0; pause = 0; keys = 4'hF;
        test_reset();
        test_anim();
        test_jump();
        test_priority_crouch();
        test_pause_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
